// File: rtl/control_fsm_if.sv
// Handshake and control bundle between the multi-cycle control FSM and its datapath.
// The slave modport is the FSM's view; the master modport is the datapath/bench view.
interface control_fsm_if;
  logic [6:0]  opcode;
  logic        imem_valid;
  logic        dmem_ready;
  logic        br_taken;
  logic        ir_we;
  logic        pc_we;
  logic        pc_sel;
  logic        alu_src;
  logic        mem_req;
  logic        mem_we;
  logic        rf_we;
  logic [1:0]  wb_sel;
  logic        illegal;
  logic [2:0]  state;
  logic [31:0] instret;

  modport master (
    output opcode, imem_valid, dmem_ready, br_taken,
    input  ir_we, pc_we, pc_sel, alu_src, mem_req, mem_we, rf_we, wb_sel, illegal, state,
           instret
  );

  modport slave (
    input  opcode, imem_valid, dmem_ready, br_taken,
    output ir_we, pc_we, pc_sel, alu_src, mem_req, mem_we, rf_we, wb_sel, illegal, state,
           instret
  );
endinterface

// File: rtl/control_fsm.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK/TRAP sequencing,
// datapath strobes, sticky illegal flag and retired-instruction counter.
module control_fsm (
  input logic          clk,
  input logic          rst,
  control_fsm_if.slave bus
);

  typedef enum logic [2:0] {
    StFetch     = 3'd0,
    StDecode    = 3'd1,
    StExecute   = 3'd2,
    StMem       = 3'd3,
    StWriteback = 3'd4,
    StTrap      = 3'd5
  } state_e;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  state_e      state_q;
  logic [6:0]  op_q;
  logic [31:0] instret_q;
  logic        illegal_q;

  logic        ir_we;
  logic        pc_we;
  logic        pc_sel;
  logic        alu_src;
  logic        mem_req;
  logic        mem_we;
  logic        rf_we;
  logic [1:0]  wb_sel;

  function automatic logic is_legal(input logic [6:0] op);
    logic ok;
    case (op)
      OpR, OpI, OpLui, OpAuipc, OpLoad, OpStore, OpBranch, OpJal, OpJalr: ok = 1'b1;
      default:                                                            ok = 1'b0;
    endcase
    return ok;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StFetch;
      op_q      <= 7'd0;
      instret_q <= 32'd0;
      illegal_q <= 1'b0;
    end else begin
      if (pc_we) begin
        instret_q <= instret_q + 32'd1;
      end
      case (state_q)
        StFetch: begin
          if (bus.imem_valid) state_q <= StDecode;
        end
        StDecode: begin
          op_q <= bus.opcode;
          if (is_legal(bus.opcode)) begin
            state_q <= StExecute;
          end else begin
            state_q   <= StTrap;
            illegal_q <= 1'b1;
          end
        end
        StExecute: begin
          if (op_q == OpBranch) begin
            state_q <= StFetch;
          end else if (op_q == OpLoad || op_q == OpStore) begin
            state_q <= StMem;
          end else begin
            state_q <= StWriteback;
          end
        end
        StMem: begin
          if (bus.dmem_ready) state_q <= (op_q == OpStore) ? StFetch : StWriteback;
        end
        StWriteback: state_q <= StFetch;
        StTrap:      state_q <= StTrap;
        default:     state_q <= StFetch;
      endcase
    end
  end

  // Strobes look only at state and op_q, never at the live opcode bus.
  always_comb begin
    ir_we   = 1'b0;
    pc_we   = 1'b0;
    pc_sel  = 1'b0;
    alu_src = 1'b0;
    mem_req = 1'b0;
    mem_we  = 1'b0;
    rf_we   = 1'b0;
    wb_sel  = 2'b00;
    case (state_q)
      StFetch: ir_we = bus.imem_valid;
      StExecute: begin
        alu_src = (op_q != OpR) && (op_q != OpBranch);
        if (op_q == OpBranch) begin
          pc_we  = 1'b1;
          pc_sel = bus.br_taken;
        end
      end
      StMem: begin
        mem_req = 1'b1;
        mem_we  = (op_q == OpStore);
        pc_we   = bus.dmem_ready && (op_q == OpStore);
      end
      StWriteback: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        pc_sel = (op_q == OpJal) || (op_q == OpJalr);
        case (op_q)
          OpLoad:        wb_sel = 2'b01;
          OpJal, OpJalr: wb_sel = 2'b10;
          OpLui:         wb_sel = 2'b11;
          default:       wb_sel = 2'b00;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.ir_we   = ir_we;
  assign bus.pc_we   = pc_we;
  assign bus.pc_sel  = pc_sel;
  assign bus.alu_src = alu_src;
  assign bus.mem_req = mem_req;
  assign bus.mem_we  = mem_we;
  assign bus.rf_we   = rf_we;
  assign bus.wb_sel  = wb_sel;
  assign bus.illegal = illegal_q;
  assign bus.state   = state_q;
  assign bus.instret = instret_q;

endmodule

// File: tb/tb_control_fsm.sv
// Bench for control_fsm: per-instruction expected cycle traces built from the
// instruction's class, wait states and branch outcome, compared every cycle.
module tb_control_fsm;

  localparam logic [6:0] OpR      = 7'b0110011;
  localparam logic [6:0] OpI      = 7'b0010011;
  localparam logic [6:0] OpLui    = 7'b0110111;
  localparam logic [6:0] OpAuipc  = 7'b0010111;
  localparam logic [6:0] OpLoad   = 7'b0000011;
  localparam logic [6:0] OpStore  = 7'b0100011;
  localparam logic [6:0] OpBranch = 7'b1100011;
  localparam logic [6:0] OpJal    = 7'b1101111;
  localparam logic [6:0] OpJalr   = 7'b1100111;

  typedef struct {
    bit          chk;
    logic        rst;
    logic        iv;
    logic        dr;
    logic        bt;
    logic [6:0]  op;
    logic [2:0]  st;
    logic        ir_we;
    logic        pc_we;
    logic        pc_sel;
    logic        alu_src;
    logic        mem_req;
    logic        mem_we;
    logic        rf_we;
    logic [1:0]  wb_sel;
    logic [31:0] ir;
  } cyc_t;

  logic clk = 1'b0;
  logic rst;
  control_fsm_if bus ();

  control_fsm dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  cyc_t        exp_q[$];
  cyc_t        cur;
  logic [2:0]  st_log[$];
  int          mreq_cnt;
  logic [31:0] m_instret;
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [6:0]  legal_ops[9] = '{OpR, OpI, OpLui, OpAuipc, OpLoad, OpStore, OpBranch, OpJal,
                                OpJalr};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit tb_legal(input logic [6:0] op);
    return op inside {OpR, OpI, OpLui, OpAuipc, OpLoad, OpStore, OpBranch, OpJal, OpJalr};
  endfunction

  // Every expected output of the cycle defaults to 0; irrelevant inputs are randomized.
  function automatic cyc_t blank(input logic [2:0] st);
    cyc_t c;
    c.chk     = 1'b1;
    c.rst     = 1'b0;
    c.iv      = 1'($urandom_range(0, 1));
    c.dr      = 1'($urandom_range(0, 1));
    c.bt      = 1'($urandom_range(0, 1));
    c.op      = 7'($urandom);
    c.st      = st;
    c.ir_we   = 1'b0;
    c.pc_we   = 1'b0;
    c.pc_sel  = 1'b0;
    c.alu_src = 1'b0;
    c.mem_req = 1'b0;
    c.mem_we  = 1'b0;
    c.rf_we   = 1'b0;
    c.wb_sel  = 2'b00;
    c.ir      = 32'd0;
    return c;
  endfunction

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
      if (cur.chk) begin
        check("state", 32'(bus.state), 32'(cur.st));
        check("ir_we", 32'(bus.ir_we), 32'(cur.ir_we));
        check("pc_we", 32'(bus.pc_we), 32'(cur.pc_we));
        check("pc_sel", 32'(bus.pc_sel), 32'(cur.pc_sel));
        check("alu_src", 32'(bus.alu_src), 32'(cur.alu_src));
        check("mem_req", 32'(bus.mem_req), 32'(cur.mem_req));
        check("mem_we", 32'(bus.mem_we), 32'(cur.mem_we));
        check("rf_we", 32'(bus.rf_we), 32'(cur.rf_we));
        check("wb_sel", 32'(bus.wb_sel), 32'(cur.wb_sel));
        check("illegal", 32'(bus.illegal), 32'(cur.st == 3'd5));
        check("instret", bus.instret, cur.ir);
        check("excl_we", 32'((int'(bus.ir_we) + int'(bus.rf_we) + int'(bus.mem_we)) <= 1), 32'd1);
        st_log.push_back(bus.state);
        if (bus.mem_req) mreq_cnt++;
      end
    end
  end

  task automatic step(input cyc_t c);
    @(posedge clk);
    #1;
    rst            = c.rst;
    bus.imem_valid = c.iv;
    bus.dmem_ready = c.dr;
    bus.br_taken   = c.bt;
    bus.opcode     = c.op;
    c.ir           = m_instret;
    exp_q.push_back(c);
    if (c.rst) m_instret = 32'd0;
    else if (c.pc_we) m_instret = m_instret + 32'd1;
  endtask

  task automatic idle_step();
    cyc_t c;
    c    = blank(3'd0);
    c.iv = 1'b0;
    step(c);
  endtask

  // fw fetch stalls, mw memory stalls; rst_mem asserts rst in the first MEM cycle.
  task automatic run_instr(input logic [6:0] op, input logic bt, input int fw, input int mw,
                           input bit rst_mem, output int n);
    cyc_t c;
    bit   is_ls;
    bit   is_st;
    n = 0;
    for (int i = 0; i < fw; i++) begin
      c    = blank(3'd0);
      c.iv = 1'b0;
      step(c);
      n++;
    end
    c       = blank(3'd0);
    c.iv    = 1'b1;
    c.ir_we = 1'b1;
    step(c);
    n++;
    c    = blank(3'd1);
    c.op = op;
    step(c);
    n++;
    if (!tb_legal(op)) return;
    is_ls     = (op == OpLoad) || (op == OpStore);
    is_st     = (op == OpStore);
    c         = blank(3'd2);
    c.alu_src = (op != OpR) && (op != OpBranch);
    if (op == OpBranch) begin
      c.bt     = bt;
      c.pc_we  = 1'b1;
      c.pc_sel = bt;
    end
    step(c);
    n++;
    if (op == OpBranch) return;
    if (is_ls) begin
      if (rst_mem) begin
        c         = blank(3'd3);
        c.rst     = 1'b1;
        c.mem_req = 1'b1;
        c.mem_we  = is_st;
        c.pc_we   = is_st && c.dr;
        step(c);
        n++;
        return;
      end
      for (int i = 0; i < mw; i++) begin
        c         = blank(3'd3);
        c.dr      = 1'b0;
        c.mem_req = 1'b1;
        c.mem_we  = is_st;
        step(c);
        n++;
      end
      c         = blank(3'd3);
      c.dr      = 1'b1;
      c.mem_req = 1'b1;
      c.mem_we  = is_st;
      c.pc_we   = is_st;
      step(c);
      n++;
      if (is_st) return;
    end
    c        = blank(3'd4);
    c.rf_we  = 1'b1;
    c.pc_we  = 1'b1;
    c.pc_sel = (op == OpJal) || (op == OpJalr);
    case (op)
      OpLoad:        c.wb_sel = 2'b01;
      OpJal, OpJalr: c.wb_sel = 2'b10;
      OpLui:         c.wb_sel = 2'b11;
      default:       c.wb_sel = 2'b00;
    endcase
    step(c);
    n++;
  endtask

  task automatic trap_then_reset(input int k);
    cyc_t c;
    for (int i = 0; i < k; i++) step(blank(3'd5));
    c     = blank(3'd5);
    c.rst = 1'b1;
    step(c);
  endtask

  initial begin
    cyc_t       c;
    int         n;
    logic [6:0] op;
    rst            = 1'b1;
    bus.imem_valid = 1'b0;
    bus.dmem_ready = 1'b0;
    bus.br_taken   = 1'b0;
    bus.opcode     = 7'd0;
    m_instret      = 32'd0;
    mreq_cnt       = 0;
    for (int i = 0; i < 2; i++) begin
      c     = blank(3'd0);
      c.chk = 1'b0;
      c.rst = 1'b1;
      step(c);
    end
    idle_step();
    @(negedge clk); #1;
    check("reset_state", 32'(bus.state), 32'd0);
    check("reset_instret", bus.instret, 32'd0);
    check("reset_illegal", 32'(bus.illegal), 32'd0);

    st_log.delete();
    run_instr(OpR, 1'b0, 0, 0, 1'b0, n);
    idle_step();
    @(negedge clk); #1;
    check("add_len", 32'(st_log.size()), 32'd5);
    check("add_states", {17'd0, st_log[0], st_log[1], st_log[2], st_log[3], st_log[4]},
          {17'd0, 3'd0, 3'd1, 3'd2, 3'd4, 3'd0});
    check("add_instret", bus.instret, 32'd1);

    run_instr(OpLui, 1'b0, 1, 0, 1'b0, n);
    idle_step();
    @(negedge clk); #1;
    check("lui_instret", bus.instret, 32'd2);

    mreq_cnt = 0;
    run_instr(OpLoad, 1'b0, 0, 3, 1'b0, n);
    check("load_cycles", 32'(n), 32'd8);
    idle_step();
    @(negedge clk); #1;
    check("load_mreq_cycles", 32'(mreq_cnt), 32'd4);

    run_instr(OpBranch, 1'b1, 0, 0, 1'b0, n);
    check("branch_cycles", 32'(n), 32'd3);
    run_instr(OpBranch, 1'b0, 0, 0, 1'b0, n);
    idle_step();
    @(negedge clk); #1;
    check("branch_instret", bus.instret, 32'd5);

    run_instr(7'b0000000, 1'b0, 0, 0, 1'b0, n);
    for (int i = 0; i < 10; i++) step(blank(3'd5));
    @(negedge clk); #1;
    check("trap_state", 32'(bus.state), 32'd5);
    check("trap_illegal", 32'(bus.illegal), 32'd1);
    check("trap_instret", bus.instret, 32'd5);
    trap_then_reset(0);
    idle_step();
    @(negedge clk); #1;
    check("trap_rst_state", 32'(bus.state), 32'd0);
    check("trap_rst_illegal", 32'(bus.illegal), 32'd0);

    run_instr(OpStore, 1'b0, 0, 2, 1'b1, n);
    idle_step();
    @(negedge clk); #1;
    check("st_rst_state", 32'(bus.state), 32'd0);
    check("st_rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("st_rst_instret", bus.instret, 32'd0);

    dut.instret_q = 32'hFFFF_FFFE;
    m_instret     = 32'hFFFF_FFFE;
    run_instr(OpR, 1'b0, 0, 0, 1'b0, n);
    run_instr(OpI, 1'b0, 0, 0, 1'b0, n);
    idle_step();
    @(negedge clk); #1;
    check("instret_wrap", bus.instret, 32'd0);

    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 9) != 0) op = legal_ops[$urandom_range(0, 8)];
      else op = 7'($urandom);
      run_instr(op, 1'($urandom_range(0, 1)), $urandom_range(0, 2), $urandom_range(0, 2),
                ($urandom_range(0, 19) == 0), n);
      if (!tb_legal(op)) trap_then_reset($urandom_range(0, 3));
    end

    idle_step();
    @(negedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
